// File: rtl/wb_reg_arb_pkg.sv
// Shared types and constants for the two-master Wishbone register-table arbiter.
// The optional watchdog is enabled with the WB_REG_ARB_TIMEOUT_EN macro.
package wb_reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_ABORT  = 2'd3
  } arb_state_e;

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  localparam int CNT_W = 4;
  localparam int TMR_W = 16;

endpackage

// File: rtl/wb_reg_arb_timer.sv
// Watchdog down-counter: i_clr reloads LOAD_VALUE and clears the expiry flag,
// o_expired is registered and rises on the edge where the count reaches zero.
module wb_reg_arb_timer
  import wb_reg_arb_pkg::*;
#(
  parameter int LOAD_VALUE = 254
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] LOAD = TMR_W'(LOAD_VALUE);
  localparam logic [TMR_W-1:0] ONE  = TMR_W'(1);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (i_clr) begin
      cnt_d     = LOAD;
      expired_d = 1'b0;
    end else if (i_en && cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
      if (cnt_q == ONE) expired_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q     <= LOAD;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign o_expired = expired_q;

endmodule

// File: rtl/wb_reg_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the 8-bit register table.
// Define WB_REG_ARB_TIMEOUT_EN to compile in the hung-cycle watchdog and ABORT state.
module wb_reg_arbiter
  import wb_reg_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_m0_wb_cyc,
  input  logic                     i_m0_wb_stb,
  output logic                     o_m0_wb_stall,
  input  logic [ADDRESS_WIDTH-1:0] i_m0_wb_adr,
  input  logic                     i_m0_wb_we,
  input  logic [7:0]               i_m0_wb_dat,
  input  logic                     i_m0_wb_sel,
  output logic                     o_m0_wb_ack,
  output logic                     o_m0_wb_err,
  output logic                     o_m0_wb_rty,
  output logic [7:0]               o_m0_wb_dat,
  input  logic                     i_m1_wb_cyc,
  input  logic                     i_m1_wb_stb,
  output logic                     o_m1_wb_stall,
  input  logic [ADDRESS_WIDTH-1:0] i_m1_wb_adr,
  input  logic                     i_m1_wb_we,
  input  logic [7:0]               i_m1_wb_dat,
  input  logic                     i_m1_wb_sel,
  output logic                     o_m1_wb_ack,
  output logic                     o_m1_wb_err,
  output logic                     o_m1_wb_rty,
  output logic [7:0]               o_m1_wb_dat,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic [ADDRESS_WIDTH-1:0] o_wb_adr,
  output logic                     o_wb_we,
  output logic [7:0]               o_wb_dat,
  output logic                     o_wb_sel,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic                     i_wb_rty,
  input  logic [7:0]               i_wb_dat,
  output logic [1:0]               o_grant
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;   // last granted master; owns the bus in GRANT/ABORT
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                     own_cyc, own_stb, own_we, own_sel, oth_cyc;
  logic [ADDRESS_WIDTH-1:0] own_adr;
  logic [7:0]               own_dat;
  logic                     full, resp, granted, accept;
  logic                     fwd_stall, fwd_ack, fwd_err, fwd_rty;
  logic [7:0]               fwd_dat;
  logic                     tmr_expired;

  assign own_cyc = (last_q == GRANT_M1) ? i_m1_wb_cyc : i_m0_wb_cyc;
  assign own_stb = (last_q == GRANT_M1) ? i_m1_wb_stb : i_m0_wb_stb;
  assign own_we  = (last_q == GRANT_M1) ? i_m1_wb_we  : i_m0_wb_we;
  assign own_sel = (last_q == GRANT_M1) ? i_m1_wb_sel : i_m0_wb_sel;
  assign own_adr = (last_q == GRANT_M1) ? i_m1_wb_adr : i_m0_wb_adr;
  assign own_dat = (last_q == GRANT_M1) ? i_m1_wb_dat : i_m0_wb_dat;
  assign oth_cyc = (last_q == GRANT_M1) ? i_m0_wb_cyc : i_m1_wb_cyc;

  assign full    = (cnt_q == MAX_CNT);
  assign resp    = i_wb_ack | i_wb_err | i_wb_rty;
  assign granted = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
  assign accept  = granted & own_stb & ~full & ~i_wb_stall;

`ifdef WB_REG_ARB_TIMEOUT_EN
  logic abort_first_q, abort_first_d;
  logic tmr_clr;

  // Restart on any response, an empty pipeline, or a grant change.
  assign tmr_clr = resp | (cnt_q == '0) | (state_d != state_q);

  wb_reg_arb_timer #(
    .LOAD_VALUE(TIMEOUT_CYCLES - 1)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (tmr_clr),
    .i_en     (~tmr_clr),
    .o_expired(tmr_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmr_expired    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_adr  = '0;
    o_wb_we   = 1'b0;
    o_wb_dat  = '0;
    o_wb_sel  = 1'b0;
    o_grant   = 2'b00;
    fwd_stall = 1'b1;
    fwd_ack   = 1'b0;
    fwd_err   = 1'b0;
    fwd_rty   = 1'b0;
    fwd_dat   = '0;
`ifdef WB_REG_ARB_TIMEOUT_EN
    abort_first_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_m0_wb_cyc && (!i_m1_wb_cyc || last_q == GRANT_M1)) begin
          state_d = ST_GRANT0;
          last_d  = GRANT_M0;
        end else if (i_m1_wb_cyc) begin
          state_d = ST_GRANT1;
          last_d  = GRANT_M1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        o_wb_cyc  = own_cyc;
        o_wb_stb  = own_stb & ~full;
        o_wb_adr  = own_adr;
        o_wb_we   = own_we;
        o_wb_dat  = own_dat;
        o_wb_sel  = own_sel;
        o_grant   = (last_q == GRANT_M1) ? 2'b10 : 2'b01;
        fwd_stall = i_wb_stall | full;
        fwd_ack   = i_wb_ack;
        fwd_err   = i_wb_err;
        fwd_rty   = i_wb_rty;
        fwd_dat   = i_wb_dat;
        if (accept && !resp) cnt_d = cnt_q + CNT_ONE;
        else if (!accept && resp && cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        if (!own_cyc) begin
          cnt_d = '0;
          if (oth_cyc) begin
            state_d = (last_q == GRANT_M1) ? ST_GRANT0 : ST_GRANT1;
            last_d  = ~last_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmr_expired) begin
          cnt_d = '0;
`ifdef WB_REG_ARB_TIMEOUT_EN
          state_d       = ST_ABORT;
          abort_first_d = 1'b1;
`endif
        end
      end
`ifdef WB_REG_ARB_TIMEOUT_EN
      ST_ABORT: begin
        cnt_d   = '0;
        fwd_err = abort_first_q;
        if (!own_cyc) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    o_m0_wb_stall = 1'b1;
    o_m0_wb_ack   = 1'b0;
    o_m0_wb_err   = 1'b0;
    o_m0_wb_rty   = 1'b0;
    o_m0_wb_dat   = '0;
    o_m1_wb_stall = 1'b1;
    o_m1_wb_ack   = 1'b0;
    o_m1_wb_err   = 1'b0;
    o_m1_wb_rty   = 1'b0;
    o_m1_wb_dat   = '0;
    // In IDLE the forwarded values equal the idle defaults, so routing is unconditional.
    if (last_q == GRANT_M0) begin
      o_m0_wb_stall = fwd_stall;
      o_m0_wb_ack   = fwd_ack;
      o_m0_wb_err   = fwd_err;
      o_m0_wb_rty   = fwd_rty;
      o_m0_wb_dat   = fwd_dat;
    end else begin
      o_m1_wb_stall = fwd_stall;
      o_m1_wb_ack   = fwd_ack;
      o_m1_wb_err   = fwd_err;
      o_m1_wb_rty   = fwd_rty;
      o_m1_wb_dat   = fwd_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= GRANT_M1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WB_REG_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) abort_first_q <= 1'b0;
    else          abort_first_q <= abort_first_d;
  end
`endif

endmodule

// File: tb/tb_wb_reg_arbiter.sv
// Directed bench for wb_reg_arbiter; the watchdog scenario runs only when
// WB_REG_ARB_TIMEOUT_EN is defined.
module tb_wb_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_cyc, m0_stb, m0_we, m0_sel, m1_cyc, m1_stb, m1_we, m1_sel;
  logic [7:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic       m0_stall, m0_ack, m0_err, m0_rty, m1_stall, m1_ack, m1_err, m1_rty;
  logic [7:0] m0_rdat, m1_rdat;
  logic       wb_cyc, wb_stb, wb_we, wb_sel;
  logic [7:0] wb_adr, wb_wdat;
  logic       s_stall, s_ack, s_err, s_rty;
  logic [7:0] s_dat;
  logic [1:0] grant;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  wb_reg_arbiter #(
    .ADDRESS_WIDTH  (8),
    .MAX_OUTSTANDING(4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .o_m0_wb_stall(m0_stall),
    .i_m0_wb_adr(m0_adr), .i_m0_wb_we(m0_we), .i_m0_wb_dat(m0_dat), .i_m0_wb_sel(m0_sel),
    .o_m0_wb_ack(m0_ack), .o_m0_wb_err(m0_err), .o_m0_wb_rty(m0_rty), .o_m0_wb_dat(m0_rdat),
    .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .o_m1_wb_stall(m1_stall),
    .i_m1_wb_adr(m1_adr), .i_m1_wb_we(m1_we), .i_m1_wb_dat(m1_dat), .i_m1_wb_sel(m1_sel),
    .o_m1_wb_ack(m1_ack), .o_m1_wb_err(m1_err), .o_m1_wb_rty(m1_rty), .o_m1_wb_dat(m1_rdat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_adr(wb_adr), .o_wb_we(wb_we),
    .o_wb_dat(wb_wdat), .o_wb_sel(wb_sel),
    .i_wb_stall(s_stall), .i_wb_ack(s_ack), .i_wb_err(s_err), .i_wb_rty(s_rty),
    .i_wb_dat(s_dat),
    .o_grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc_next();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_adr = '0; m0_dat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = '0; m1_dat = '0;
    s_stall = 0; s_ack = 0; s_err = 0; s_rty = 0; s_dat = '0;
  endtask

  task automatic reset_dut();
    rst_n = 0;
    idle_inputs();
    cyc_next();
    cyc_next();
    rst_n = 1;
  endtask

  // Holds m1's strobe for n cycles of an existing grant and returns the accepted count.
  task automatic count_accepts(input int n, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      cyc_mid();
      if (wb_stb && !s_stall) acc++;
      cyc_next();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [7:0] e;
    rst_n = 0;
    idle_inputs();
    cyc_next();
    cyc_next();
    cyc_mid();
    check("rst_grant", 32'(grant), 0);
    check("rst_m0_stall", 32'(m0_stall), 1);
    check("rst_m1_stall", 32'(m1_stall), 1);
    check("rst_wb_cyc", 32'(wb_cyc), 0);
    check("rst_wb_stb", 32'(wb_stb), 0);
    cyc_next();
    rst_n = 1;

    // m0 single read of 0x00, slave answers 0xA5
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 8'h00;
    exp_q.push_back(8'hA5);
    cyc_mid();
    check("t1_arb_cycle_grant", 32'(grant), 0);
    cyc_next();
    cyc_mid();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_wb_stb", 32'(wb_stb), 1);
    check("t1_wb_adr", 32'(wb_adr), 32'h00);
    check("t1_m0_stall", 32'(m0_stall), 0);
    check("t1_m1_stall_a", 32'(m1_stall), 1);
    cyc_next();
    m0_stb = 0;
    cyc_mid();
    check("t1_wait_m0_ack", 32'(m0_ack), 0);
    cyc_next();
    s_ack = 1; s_dat = 8'hA5;
    cyc_mid();
    check("t1_m0_ack", 32'(m0_ack), 1);
    if (m0_ack && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("t1_m0_rdata", 32'(m0_rdat), 32'(e));
    end
    check("t1_m1_ack", 32'(m1_ack), 0);
    check("t1_m1_dat", 32'(m1_rdat), 0);
    check("t1_m1_stall_b", 32'(m1_stall), 1);
    cyc_next();
    s_ack = 0; s_dat = '0; m0_cyc = 0;
    cyc_mid();
    check("t1_release_grant", 32'(grant), 32'h1);
    check("t1_release_wb_cyc", 32'(wb_cyc), 0);
    cyc_next();
    cyc_mid();
    check("t1_idle_grant", 32'(grant), 0);
    check("t1_scoreboard_empty", 32'(exp_q.size()), 0);
    cyc_next();

    // Collision from reset, handover, then a second collision
    reset_dut();
    m0_cyc = 1; m1_cyc = 1;
    cyc_next();
    cyc_mid();
    check("t2_first_grant", 32'(grant), 32'h1);
    check("t2_m1_stall", 32'(m1_stall), 1);
    cyc_next();
    m0_cyc = 0;
    cyc_mid();
    check("t2_drop_cycle_grant", 32'(grant), 32'h1);
    cyc_next();
    cyc_mid();
    check("t2_handover_grant", 32'(grant), 32'h2);
    check("t2_handover_wb_cyc", 32'(wb_cyc), 1);
    check("t2_m0_stall", 32'(m0_stall), 1);
    cyc_next();
    m1_cyc = 0;
    cyc_next();
    cyc_mid();
    check("t2_idle_grant", 32'(grant), 0);
    cyc_next();
    m0_cyc = 1; m1_cyc = 1;
    cyc_next();
    cyc_mid();
    check("t2_rr_grant", 32'(grant), 32'h1);
    cyc_next();
    m0_cyc = 0; m1_cyc = 0;
    cyc_next();
    cyc_next();

    // m1 back-to-back writes, slave never acks: depth limit of 4
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 1; m1_adr = 8'h10; m1_dat = 8'h3C;
    cyc_next();
    count_accepts(8, acc);
    check("t3_accepted", 32'(acc), 4);
    cyc_mid();
    check("t3_full_stall", 32'(m1_stall), 1);
    check("t3_full_wb_stb", 32'(wb_stb), 0);
    check("t3_full_wb_we", 32'(wb_we), 1);
    cyc_next();
    s_ack = 1;
    cyc_mid();
    check("t3_ack_fwd", 32'(m1_ack), 1);
    check("t3_ack_cycle_stall", 32'(m1_stall), 1);
    check("t3_m0_ack", 32'(m0_ack), 0);
    cyc_next();
    s_ack = 0;
    cyc_mid();
    check("t3_after_ack_stall", 32'(m1_stall), 0);
    check("t3_after_ack_stb", 32'(wb_stb), 1);
    cyc_next();
    m1_cyc = 0; m1_stb = 0;
    cyc_next();
    cyc_mid();
    check("t3_idle_grant", 32'(grant), 0);
    cyc_next();

    // Reset with 2 outstanding on m1, then a late ack
    m1_cyc = 1; m1_stb = 1;
    cyc_next();
    count_accepts(2, acc);
    check("t5_pre_accepts", 32'(acc), 2);
    m1_stb = 0; rst_n = 0;
    cyc_next();
    s_ack = 1;
    cyc_mid();
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_m0_stall", 32'(m0_stall), 1);
    check("t5_rst_m1_stall", 32'(m1_stall), 1);
    check("t5_rst_wb_cyc", 32'(wb_cyc), 0);
    check("t5_late_ack_m1", 32'(m1_ack), 0);
    check("t5_late_ack_m0", 32'(m0_ack), 0);
    cyc_next();
    rst_n = 1; m1_cyc = 0;
    cyc_mid();
    check("t5_idle_late_ack_m1", 32'(m1_ack), 0);
    cyc_next();
    s_ack = 0; m1_cyc = 1; m1_stb = 1;
    cyc_next();
    count_accepts(7, acc);
    check("t5_count_cleared", 32'(acc), 4);
    m1_cyc = 0; m1_stb = 0;
    cyc_next();
    cyc_next();

`ifdef WB_REG_ARB_TIMEOUT_EN
    // Hung slave: one err pulse 16 cycles after acceptance, bus freed
    begin
      int pulses = 0;
      int err_at = -1;
      logic cyc_at_err = 1'b1;
      logic stall_after = 1'b0;
      m0_cyc = 1; m0_stb = 1; m0_adr = 8'h22;
      cyc_next();
      cyc_next();
      m0_stb = 0;
      for (int j = 0; j < 20; j++) begin
        cyc_mid();
        if (m0_err) begin
          pulses++;
          if (err_at < 0) begin
            err_at = j;
            cyc_at_err = wb_cyc;
          end
        end
        if (j == 17) stall_after = m0_stall;
        cyc_next();
      end
      check("t4_err_pulses", 32'(pulses), 1);
      check("t4_err_cycle", 32'(err_at), 16);
      check("t4_abort_wb_cyc", 32'(cyc_at_err), 0);
      check("t4_abort_stall", 32'(stall_after), 1);
      m0_cyc = 0;
      cyc_next();
      cyc_mid();
      check("t4_idle_grant", 32'(grant), 0);
      check("t4_idle_m0_stall", 32'(m0_stall), 1);
      cyc_next();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_reg_arbiter.md
# wb_reg_arbiter

Two-master Wishbone arbiter that shares the 8-bit pipelined register-table slave between the SiTCP RBCP bridge (master 0) and an on-chip local master (master 1). It sits directly in front of the generated register table's Wishbone slave port. Arbitration is round-robin with a registered grant. Each grant holds for a whole bus cycle (`cyc`). An outstanding-transaction counter limits the pipeline depth, and an optional watchdog aborts hung cycles.

## Interface
Parameters:
- ADDRESS_WIDTH, 8, width of the Wishbone address on all ports.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered strobes per grant; range 1..15.
- TIMEOUT_CYCLES, 255, watchdog limit in clocks; range 2..65535; only used when the watchdog is compiled in.

Ports (clock and reset first; m = 0 or 1):
- i_clk  in  1  single clock for all logic.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_m{m}_wb_cyc  in  1  master cycle.
- i_m{m}_wb_stb  in  1  master strobe.
- o_m{m}_wb_stall  out  1  master stall.
- i_m{m}_wb_adr  in  ADDRESS_WIDTH  master address.
- i_m{m}_wb_we  in  1  master write enable.
- i_m{m}_wb_dat  in  8  master write data.
- i_m{m}_wb_sel  in  1  master byte select.
- o_m{m}_wb_ack / o_m{m}_wb_err / o_m{m}_wb_rty  out  1 each  master responses.
- o_m{m}_wb_dat  out  8  master read data.
- o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_we, o_wb_dat, o_wb_sel  out  as above  slave request.
- i_wb_stall, i_wb_ack, i_wb_err, i_wb_rty, i_wb_dat  in  as above  slave response.
- o_grant  out  2  one-hot current grant (bit m = master m); 2'b00 when no master is granted.

## Operation
State machine states: IDLE, GRANT0, GRANT1, ABORT. ABORT exists only with the watchdog compiled in.

- **Reset.** State = IDLE. Round-robin pointer set so m0 has priority. Outstanding count = 0. Timer = 0.
- **Request.** Master m requests when `i_m{m}_wb_cyc` = 1.
- **IDLE.**
  - Only one master requests: go to that master's GRANT state.
  - Both request: grant the master that was not granted last. After reset, m0 wins.
- **GRANTm, routing.**
  - Slave request = master m's request signals.
  - Master m sees `o_m{m}_wb_stall` = `i_wb_stall` OR (outstanding == MAX_OUTSTANDING).
  - `o_wb_stb` = `i_m{m}_wb_stb` AND NOT (outstanding == MAX_OUTSTANDING).
  - Master m's ack/err/rty/dat come from the slave.
  - The other master sees stall = 1, ack/err/rty = 0, dat = 0.
- **GRANTm, release.** When `i_m{m}_wb_cyc` = 0:
  - If the other master is requesting, go directly to its GRANT state.
  - Otherwise go to IDLE.
  - Outstanding count is cleared. Late slave responses are dropped (not forwarded to any master).
- **Outstanding count.**
  - +1 when a strobe is accepted: `o_wb_stb` AND NOT `i_wb_stall`.
  - −1 on any of `i_wb_ack` / `i_wb_err` / `i_wb_rty`.
  - Both in the same cycle: count unchanged.
  - A response when the count is 0 is ignored; the count never goes negative.
- **Watchdog.**
  - Timer counts while outstanding > 0 and no response arrives.
  - Timer clears on any response, on grant change, or when outstanding == 0.
  - When the timer reaches TIMEOUT_CYCLES−1, go to ABORT.
- **ABORT.**
  - `o_wb_cyc` / `o_wb_stb` = 0.
  - Granted master: err = 1 for the first ABORT cycle only, stall = 1 throughout.
  - Outstanding count cleared.
  - Stay in ABORT until the granted master drops cyc, then go to IDLE.
- **Non-granted outputs.** Slave-side request outputs are 0 whenever no master is granted (IDLE and ABORT).
- **Reset mid-cycle.** Next edge: IDLE, all of the reset values above, and no response pulses.

## Timing
- Grant is registered: a request at edge N is granted and driven to the slave at N+1. Arbitration latency is 1 cycle.
- Within a grant the data path is combinational. Arbiter latency is 0 for strobes, stall and responses.
- Handover with both masters requesting: m0 drops cyc at edge N; m1 drives the slave from N+1. No idle cycle.
- Output values in reset and IDLE:
  - `o_m{m}_wb_stall` = 1.
  - Every other output = 0, including `o_grant` = 2'b00.
- Watchdog: the last request/response activity is at edge N. ABORT is entered at N+TIMEOUT_CYCLES, and the err pulse occurs in that cycle.

## Configuration
- WB_REG_ARB_TIMEOUT_EN is defined:
  - The watchdog timer and the ABORT state are compiled in.
  - A hung slave produces one err pulse to the granted master and frees the bus.
- WB_REG_ARB_TIMEOUT_EN is undefined:
  - No timer and no ABORT state; TIMEOUT_CYCLES is ignored.
  - Err comes only from the slave.
  - A grant lasts until the master drops cyc.

## Structure
- Package `wb_reg_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2, ABORT=2'd3);
  - the grant index constants;
  - the outstanding-counter width (4).
- Sub-module `wb_reg_arb_timer`:
  - a loadable down-counter with a clear input and a registered expiry flag;
  - instantiated only under WB_REG_ARB_TIMEOUT_EN.

## Test plan
- m0 read of adr 8'h00, slave acks with 8'hA5 after 2 cycles -> `o_grant`=2'b01 one cycle after cyc; `o_m0_wb_dat`=8'hA5 with ack; m1 sees stall=1 and ack=0 throughout.
- m0 and m1 assert cyc in the same cycle from reset -> m0 granted first; when m0 drops cyc, m1 is granted on the next edge. A second collision then grants m0 again (round-robin).
- m1 issues 6 back-to-back strobes, slave never stalls and holds ack low, MAX_OUTSTANDING=4 -> exactly 4 strobes accepted; `o_m1_wb_stall`=1 until the first ack.
- WB_REG_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, m0 strobe accepted, no slave response -> `o_m0_wb_err` pulses 16 cycles after acceptance; `o_wb_cyc`=0; IDLE one cycle after m0 drops cyc.
- Reset asserted while m1 has 2 outstanding -> next edge `o_grant`=0, all stalls=1, count=0; a subsequent late slave ack is forwarded to neither master.
